// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory path: default data/address widths
// and the state encoding of the memory access unit FSM. Imported by
// mem_access_unit, data_memory and the MEM pipeline stage.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_ADDR_WIDTH = 16;

  // Fixed encoding so the state is readable on a bus trace.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STORE     = 2'd1,
    LOAD_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

endpackage : mem_pkg

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the data memory interface. Accepts one load or store at a
// time over a valid/ready handshake, drives the memory ports, waits out the
// memory read latency and returns a single-cycle response.
//
// Ports
//   clock, reset_n            system clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (req_ready is registered)
//   req_write                 1 = store, 0 = load
//   req_address, req_wdata    word address and store data
//   resp_valid                one-cycle response pulse, no back-pressure
//   resp_rdata                load data, 0 for stores and faults
//   resp_fault                address out of range, qualified by resp_valid
//   busy                      state is not IDLE
//   mem_write, mem_address,
//   mem_write_data            towards data_memory
//   mem_read_data             from data_memory
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int READ_LATENCY = 1,   // legal range 0..3
  parameter int MEM_DEPTH    = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,

  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  busy,

  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  // LOAD_WAIT lasts READ_LATENCY+1 cycles: the counter starts at READ_LATENCY
  // and the read data is sampled on the edge where it has reached zero.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY);

  // One extra bit so the bounds compare is unsigned over the full address
  // width even when MEM_DEPTH equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t     r_state;
  logic [1:0] r_wait_cnt;

  logic w_accept;
  logic w_in_range;

  assign w_accept   = req_valid && req_ready && (r_state == IDLE);
  assign w_in_range = ({1'b0, req_address} < DEPTH_LIMIT);
  assign busy       = (r_state != IDLE);

  // The memory-side registers double as the captured request: they are loaded
  // on the accept edge and then held, so later input changes are ignored.
  // Out-of-range requests never reach them, leaving the memory untouched.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_wait_cnt     <= '0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_fault     <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          req_ready <= 1'b1;
          if (w_accept) begin
            req_ready <= 1'b0;
            if (!w_in_range) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write) begin
              r_state        <= STORE;
              mem_write      <= 1'b1;
              mem_address    <= req_address;
              mem_write_data <= req_wdata;
            end else begin
              r_state     <= LOAD_WAIT;
              mem_address <= req_address;
              r_wait_cnt  <= WAIT_INIT;
            end
          end
        end

        STORE: begin
          r_state    <= RESP;
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
        end

        LOAD_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= mem_read_data;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end

        RESP: begin
          // Ready again for the IDLE cycle that follows; no accept in RESP.
          r_state    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
        end

        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Three instances of mem_access_unit with READ_LATENCY 1, 0 and 3, each with
// its own behavioural data memory. Expected responses are pushed to a
// scoreboard queue when a request is driven and compared when the response
// pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam int N     = 3;
  localparam logic [N-1:0][1:0] LAT = {2'd3, 2'd0, 2'd1};

  typedef struct {
    logic          w;
    logic          fault;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  logic clock;
  logic reset_n;

  logic          req_valid      [N];
  logic          req_ready      [N];
  logic          req_write      [N];
  logic [AW-1:0] req_address    [N];
  logic [DW-1:0] req_wdata      [N];
  logic          resp_valid     [N];
  logic [DW-1:0] resp_rdata     [N];
  logic          resp_fault     [N];
  logic          busy           [N];
  logic          mem_write      [N];
  logic [AW-1:0] mem_address    [N];
  logic [DW-1:0] mem_write_data [N];
  logic [DW-1:0] mem_read_data  [N];

  logic [DW-1:0] model [N][DEPTH];
  exp_t          exp_q [$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  for (genvar k = 0; k < N; k++) begin : g_dut
    logic [DW-1:0] mem_arr [DEPTH];
    logic [DW-1:0] pipe    [3];

    mem_access_unit #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(int'(LAT[k])),
      .MEM_DEPTH   (DEPTH)
    ) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid[k]),
      .req_ready     (req_ready[k]),
      .req_write     (req_write[k]),
      .req_address   (req_address[k]),
      .req_wdata     (req_wdata[k]),
      .resp_valid    (resp_valid[k]),
      .resp_rdata    (resp_rdata[k]),
      .resp_fault    (resp_fault[k]),
      .busy          (busy[k]),
      .mem_write     (mem_write[k]),
      .mem_address   (mem_address[k]),
      .mem_write_data(mem_write_data[k]),
      .mem_read_data (mem_read_data[k])
    );

    // Behavioural data_memory: synchronous write, read data valid
    // READ_LATENCY cycles after the address is stable.
    always @(posedge clock) begin
      if (mem_write[k] && (mem_address[k] < DEPTH))
        mem_arr[mem_address[k][7:0]] <= mem_write_data[k];
      pipe[0] <= mem_arr[mem_address[k][7:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    if (LAT[k] == 2'd0) begin : g_comb
      assign mem_read_data[k] = mem_arr[mem_address[k][7:0]];
    end else begin : g_pipe
      assign mem_read_data[k] = pipe[LAT[k]-1];
    end
  end

  function automatic void push(input int k, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    exp_t e;
    e.w     = w;
    e.addr  = a;
    e.data  = d;
    e.fault = (a >= DEPTH);
    e.rdata = (!e.fault && !w) ? model[k][a[7:0]] : '0;
    e.lat   = e.fault ? 0 : (w ? 1 : int'(LAT[k]) + 1);
    if (!e.fault && w) model[k][a[7:0]] = d;
    exp_q.push_back(e);
  endfunction

  // Drives one request; returns at the falling edge right after the accept.
  task automatic send(input int k, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n = 0;
    @(negedge clock);
    while (!req_ready[k] && n < 20) begin
      @(negedge clock);
      n++;
    end
    total_cnt++;
    if (req_ready[k] !== 1'b1)
      $display("FAIL ready_wait u%0d: req_ready=%b, required 1 within 20 cycles", k, req_ready[k]);
    else pass_cnt++;
    req_valid[k]   = 1'b1;
    req_write[k]   = w;
    req_address[k] = a;
    req_wdata[k]   = d;
    push(k, w, a, d);
    @(posedge clock);
    @(negedge clock);
    // Changes after the accept must be ignored.
    req_valid[k]   = 1'b0;
    req_write[k]   = ~w;
    req_address[k] = 16'($urandom);
    req_wdata[k]   = 16'($urandom);
  endtask

  // Observes 8 cycles starting at the falling edge after the accept.
  task automatic collect(input int k);
    exp_t          e;
    int            resp_at = -1, extra = 0, mw_cnt = 0, mw_at = -1;
    logic [DW-1:0] got_rdata = '0, mw_data = '0;
    logic [AW-1:0] mw_addr = '0;
    logic          got_fault = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      if (mem_write[k]) begin
        mw_cnt++;
        if (mw_at < 0) begin
          mw_at   = i;
          mw_addr = mem_address[k];
          mw_data = mem_write_data[k];
        end
      end
      if (resp_valid[k]) begin
        if (resp_at < 0) begin
          resp_at   = i;
          got_rdata = resp_rdata[k];
          got_fault = resp_fault[k];
        end else extra++;
      end
    end
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_empty u%0d: scoreboard size=0, required >0", k);
    end else begin
      pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if (resp_at != e.lat)
        $display("FAIL resp_latency u%0d a=%0d: cycle=%0d, required %0d", k, e.addr, resp_at, e.lat);
      else pass_cnt++;
      total_cnt++;
      if (got_rdata !== e.rdata)
        $display("FAIL resp_rdata u%0d a=%0d: got %h, required %h", k, e.addr, got_rdata, e.rdata);
      else pass_cnt++;
      total_cnt++;
      if (got_fault !== e.fault)
        $display("FAIL resp_fault u%0d a=%0d: got %b, required %b", k, e.addr, got_fault, e.fault);
      else pass_cnt++;
      total_cnt++;
      if (extra != 0)
        $display("FAIL resp_pulse u%0d: extra resp_valid cycles=%0d, required 0", k, extra);
      else pass_cnt++;
      total_cnt++;
      if (mw_cnt != ((e.w && !e.fault) ? 1 : 0))
        $display("FAIL mem_write_cycles u%0d a=%0d: got %0d, required %0d", k, e.addr, mw_cnt,
                 (e.w && !e.fault) ? 1 : 0);
      else pass_cnt++;
      if (e.w && !e.fault) begin
        total_cnt++;
        if (mw_at != 0 || mw_addr !== e.addr || mw_data !== e.data)
          $display("FAIL store_port u%0d: cycle=%0d addr=%h data=%h, required cycle=0 addr=%h data=%h",
                   k, mw_at, mw_addr, mw_data, e.addr, e.data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_address[k] = '0; req_wdata[k] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < N; k++) begin
      total_cnt++;
      if ({req_ready[k], resp_valid[k], resp_fault[k], busy[k], mem_write[k]} !== 5'b0 ||
          resp_rdata[k] !== '0 || mem_address[k] !== '0 || mem_write_data[k] !== '0)
        $display("FAIL reset_values u%0d: rdy=%b rv=%b rf=%b busy=%b mw=%b rd=%h ma=%h md=%h, required all 0",
                 k, req_ready[k], resp_valid[k], resp_fault[k], busy[k], mem_write[k],
                 resp_rdata[k], mem_address[k], mem_write_data[k]);
      else pass_cnt++;
    end
    reset_n = 1'b1;
    #1;
    total_cnt++;
    if (req_ready[0] !== 1'b0)
      $display("FAIL ready_before_edge: req_ready=%b, required 0", req_ready[0]);
    else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++;
    if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL ready_after_release: req_ready=%b busy=%b, required 1 0", req_ready[0], busy[0]);
    else pass_cnt++;
  endtask

  task automatic test_store();
    send(0, 1'b1, 16'd0, 16'd42);
    collect(0);
  endtask

  task automatic test_load();
    // Instance 0 already holds 42 at address 0; prime the others the same way.
    for (int k = 0; k < N; k++) begin
      if (k != 0) begin
        send(k, 1'b1, 16'd0, 16'd42);
        collect(k);
      end
      send(k, 1'b0, 16'd0, 16'hA5A5);
      collect(k);
    end
  endtask

  task automatic test_fault();
    send(0, 1'b1, 16'd300, 16'h1234);   collect(0);
    send(0, 1'b0, 16'd256, 16'h0);      collect(0);
    send(0, 1'b0, 16'hFFFF, 16'h0);     collect(0);
    send(0, 1'b1, 16'd255, 16'hBEEF);   collect(0);
    send(0, 1'b0, 16'd255, 16'h0);      collect(0);
  endtask

  task automatic test_back_to_back();
    exp_t          e1, e2;
    int            resp1 = -1, resp2 = -1, rdy_at = -1, acc2 = -1;
    logic [DW-1:0] rd2 = '0;
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_address[0] = 16'd5; req_wdata[0] = 16'h00FF;
    push(0, 1'b1, 16'd5, 16'h00FF);
    @(posedge clock);
    @(negedge clock);
    req_write[0] = 1'b0; req_wdata[0] = 16'h1111;
    push(0, 1'b0, 16'd5, 16'h1111);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      if (resp_valid[0]) begin
        if (resp1 < 0) resp1 = i;
        else if (resp2 < 0) begin resp2 = i; rd2 = resp_rdata[0]; end
      end
      if (req_ready[0] && rdy_at < 0) rdy_at = i;
      if (rdy_at >= 0 && acc2 < 0 && busy[0]) begin
        acc2 = i;
        req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    total_cnt++;
    if (resp1 != e1.lat)
      $display("FAIL b2b_store_resp: cycle=%0d, required %0d", resp1, e1.lat);
    else pass_cnt++;
    total_cnt++;
    if (rdy_at != 2 || acc2 != 3)
      $display("FAIL b2b_accept: ready at %0d accept at %0d, required 2 3", rdy_at, acc2);
    else pass_cnt++;
    total_cnt++;
    if (resp2 != 3 + e2.lat || rd2 !== e2.rdata)
      $display("FAIL b2b_load_resp: cycle=%0d data=%h, required %0d %h", resp2, rd2, 3 + e2.lat, e2.rdata);
    else pass_cnt++;
  endtask

  task automatic reset_and_watch(input int k, input string tag);
    int stale = 0;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (mem_write[k] !== 1'b0 || resp_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
        req_ready[k] !== 1'b0 || resp_rdata[k] !== '0 || mem_address[k] !== '0)
      $display("FAIL %s_async: mw=%b rv=%b busy=%b rdy=%b rd=%h ma=%h, required all 0",
               tag, mem_write[k], resp_valid[k], busy[k], req_ready[k], resp_rdata[k], mem_address[k]);
    else pass_cnt++;
    void'(exp_q.pop_front());
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      for (int j = 0; j < N; j++) if (resp_valid[j]) stale++;
    end
    total_cnt++;
    if (stale != 0)
      $display("FAIL %s_stale_resp: resp_valid cycles=%0d, required 0", tag, stale);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    send(0, 1'b1, 16'd10, 16'h1234);
    total_cnt++;
    if (mem_write[0] !== 1'b1)
      $display("FAIL midstore_pre: mem_write=%b, required 1", mem_write[0]);
    else pass_cnt++;
    reset_and_watch(0, "midstore");

    send(2, 1'b0, 16'd0, 16'h0);
    @(negedge clock);
    total_cnt++;
    if (busy[2] !== 1'b1 || resp_valid[2] !== 1'b0)
      $display("FAIL midload_pre: busy=%b resp_valid=%b, required 1 0", busy[2], resp_valid[2]);
    else pass_cnt++;
    reset_and_watch(2, "midload");
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_mem_access_unit

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data memory interface. Takes one load or store request at a time from the MEM pipeline stage over a valid/ready handshake.
- Drives the memory ports (mem_write, address, write_data) and waits out a configurable read latency. Returns a one-cycle response with load data or a fault flag.
- Sits between the MEM stage and data_memory. Keeps handshake and timing knowledge out of the pipeline.

Parameters:
- DATA_WIDTH, 16, width of data words.
- ADDR_WIDTH, 16, width of addresses.
- READ_LATENCY, 1, number of cycles between a stable address and valid mem_read_data. Legal range is 0..3.
- MEM_DEPTH, 256, number of implemented words. Addresses >= MEM_DEPTH fault.

Ports:
- clock  in  1  system clock; all flops on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and faults.
- resp_fault  out  1  address out of range; qualified by resp_valid.
- busy  out  1  high when state is not IDLE.
- mem_write  out  1  to data_memory mem_write.
- mem_address  out  ADDR_WIDTH  to data_memory address.
- mem_write_data  out  DATA_WIDTH  to data_memory write_data.
- mem_read_data  in  DATA_WIDTH  from data_memory read_data.

Behaviour:
- Clock and reset: one clock, named clock. Reset is asynchronous and active-low, named reset_n.
- Reset values, all asynchronous and immediate while reset_n=0:
  - state=IDLE; req_ready=0; resp_valid=0; resp_rdata=0; resp_fault=0.
  - mem_write=0; mem_address=0; mem_write_data=0.
  - req_ready is registered. It rises at the first rising edge after reset_n deasserts.
- Accept condition: req_valid && req_ready at a rising edge. req_write, req_address and req_wdata are captured into internal registers at that edge. Later input changes are ignored. Inputs are ignored whenever req_ready=0.
- req_ready is 1 only while in IDLE. It drops in the cycle following an accept.
- FSM states are IDLE, STORE, LOAD_WAIT, RESP.
  - IDLE -> STORE on an accepted in-range store.
  - IDLE -> LOAD_WAIT on an accepted in-range load.
  - IDLE -> RESP on an accepted out-of-range request. resp_fault=1 and resp_rdata=0. The memory is never touched: mem_write stays 0.
  - STORE: lasts exactly 1 cycle. mem_write=1, mem_address = captured address, mem_write_data = captured data. Next state is RESP.
  - LOAD_WAIT: lasts READ_LATENCY+1 cycles, counted by a 2-bit down-counter. mem_write=0 and mem_address is held. On the final LOAD_WAIT edge, mem_read_data is registered into resp_rdata. Next state is RESP.
  - RESP: resp_valid=1 for exactly 1 cycle, with no back-pressure. Next state is IDLE.
- Latency, with accept at edge E0:
  - Store: mem_write high during E0..E1; resp_valid during E1..E2.
  - Load: resp_valid during E(L+1)..E(L+2), where L = READ_LATENCY.
  - Fault: resp_valid during E0..E1.
- Idle outputs: mem_write=0. mem_address and mem_write_data hold their last values; they are not zeroed.
- Throughput: there is no accept in RESP. Back-to-back requests therefore cost one IDLE cycle each.
- busy = (state != IDLE). It is combinational from the state register.
- Boundary cases:
  - Address MEM_DEPTH-1 is legal.
  - Address MEM_DEPTH up to 2^ADDR_WIDTH-1 faults.
  - The bounds compare is unsigned, full width.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - A store in progress is aborted: mem_write drops asynchronously.
  - No resp_valid is generated after release for the aborted request.
- No X propagation: resp_rdata is driven to 0 whenever no load response is being given.

Decomposition:
- Shared package (mem_pkg):
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - FSM state encoding localparams: IDLE=2'd0, STORE=2'd1, LOAD_WAIT=2'd2, RESP=2'd3.
  - Shared with data_memory and the MEM stage.
- No sub-module. The latency counter and bounds compare stay inline; the block is well under 400 lines.

Test Plan:
1. Hold reset_n=0 for 3 cycles, then release → all outputs 0 during reset; req_ready=1 at the first edge after release.
2. Store addr 0, data 42, accepted at E0 → mem_write=1 for exactly E0..E1 with mem_address=0 and mem_write_data=42; resp_valid=1 at E1..E2 with resp_fault=0 and resp_rdata=0.
3. Set READ_LATENCY=1 with data_memory instantiated and preloaded mem[0]=42; load addr 0 at E0 → resp_valid at E2..E3 with resp_rdata=42; mem_write stays 0 throughout. Repeat with READ_LATENCY=0 and 3 → response at E1 and E4 respectively.
4. Set MEM_DEPTH=256 and issue a store to addr 300 → mem_write never high; resp_valid plus resp_fault=1 at E0..E1. Then load addr 255 → no fault.
5. Hold req_valid high with store addr 5 data 16'h00FF followed by load addr 5 → second request accepted only in the IDLE cycle after RESP; load returns 16'h00FF.
6. Assert reset_n=0 mid-STORE and mid-LOAD_WAIT → mem_write drops to 0 and resp_valid stays 0 immediately (no clock edge needed); after release, no stale resp_valid appears within 5 cycles.
